// File: rtl/pck_flit_depacketizer.sv
// Purpose: ejection-port receiver that buffers flits per VC, returns credits and delivers whole packets with decoded header fields.
// Latency: a flit written in cycle t can be presented at t+1; the credit for a pop in cycle t pulses in cycle t+1.
// Backpressure: out_ready low holds the head flit and its flags stable; upstream is throttled only by withheld credits.
module pck_flit_depacketizer #(
   parameter  int NOC_ID       = 0,
   parameter  int DATA_w       = 9,
   parameter  int B            = 4,
   parameter  int MAX_PCK_FLIT = 16,
   // NoC configuration set; set 0 is the default ejection-port layout
   localparam int V            = (NOC_ID == 1) ? 4 : 2,
   localparam int FPAYw        = (NOC_ID == 1) ? 64 : 32,
   localparam int EAw          = (NOC_ID == 1) ? 6 : 4,
   localparam int C            = (NOC_ID == 1) ? 4 : 1,
   localparam int Cw           = (C > 1) ? $clog2(C) : 1,
   localparam int WEIGHTw      = 4,
   localparam int BEw          = 2,
   localparam int Fw           = FPAYw + V + 2,
   localparam int DOw          = (DATA_w > 1) ? DATA_w : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [Fw-1:0]      flit_in,
   input  logic               flit_in_wr,
   output logic [V-1:0]       credit_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FPAYw-1:0]   out_payload,
   output logic [V-1:0]       out_vc,
   output logic               out_sop,
   output logic               out_eop,
   output logic [EAw-1:0]     out_src_e_addr,
   output logic [Cw-1:0]      out_class,
   output logic [DOw-1:0]     out_data,
   output logic               err_orphan,
   output logic               err_hdr_in_body,
   output logic               err_too_long,
   output logic               err_overflow,
   output logic [31:0]        rx_pck_count
);

   // Header layout inside the payload: dst at the bottom, then src, class (only when C>1), weight, byte-enable, data
   localparam int SRC_LSB    = EAw;
   localparam int CLASS_LSB  = 2 * EAw;
   localparam int WEIGHT_LSB = CLASS_LSB + ((C > 1) ? Cw : 0);
   localparam int BE_LSB     = WEIGHT_LSB + WEIGHTw;
   localparam int MSB_BE     = BE_LSB + BEw - 1;
   localparam int DATA_LSB   = MSB_BE + 1;
   localparam int DATA_MSB   = (DATA_LSB + DATA_w - 1 > FPAYw - 1) ? FPAYw - 1 : DATA_LSB + DATA_w - 1;

   localparam int AW   = (B > 1) ? $clog2(B) : 1;
   localparam int CNTW = $clog2(B + 1);
   localparam int LENW = $clog2(MAX_PCK_FLIT + 2);
   localparam int VCw  = (V > 1) ? $clog2(V) : 1;

   typedef enum logic {ST_IDLE, ST_BODY} vc_st_t;

   function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
      return (p == AW'(B - 1)) ? '0 : p + AW'(1);
   endfunction

   logic [V-1:0]   w_vc_fld;
   logic           w_onehot;
   logic           w_hdr;
   logic           w_tail;
   logic [V-1:0]   w_empty;
   logic [V-1:0]   w_pop;
   logic [V-1:0]   w_ev_orph;
   logic [V-1:0]   w_ev_hib;
   logic [V-1:0]   w_ev_long;
   logic [V-1:0]   w_ev_ovf;
   logic [Fw-1:0]  w_head_v [V];

   logic           w_gnt_ok;
   logic [VCw-1:0] w_gnt_vc;
   logic [VCw-1:0] w_sel;
   logic           w_valid;
   logic           w_fire;
   logic [Fw-1:0]  w_head;
   logic [EAw-1:0] w_dec_src;
   logic [Cw-1:0]  w_dec_class;
   logic [DOw-1:0] w_dec_data;

   logic           r_lock;
   logic [VCw-1:0] r_lock_vc;
   logic [VCw-1:0] r_ptr;
   logic [V-1:0]   r_credit;
   logic [31:0]    r_pck_cnt;
   logic [EAw-1:0] r_src;
   logic [Cw-1:0]  r_class;
   logic [DOw-1:0] r_data;
   logic           r_err_orphan;
   logic           r_err_hib;
   logic           r_err_long;
   logic           r_err_ovf;

   assign w_vc_fld = flit_in[FPAYw+V-1:FPAYw];
   assign w_onehot = (w_vc_fld != '0) && ((w_vc_fld & (w_vc_fld - V'(1))) == '0);
   assign w_hdr    = flit_in[Fw-1];
   assign w_tail   = flit_in[Fw-2];

   for (genvar v = 0; v < V; v++) begin : g_vc
      logic             w_wr;
      logic             w_take;
      logic             w_full;
      logic             w_push;
      vc_st_t           r_st;
      logic [LENW-1:0]  r_len;
      logic [AW-1:0]    r_wp;
      logic [AW-1:0]    r_rp;
      logic [CNTW-1:0]  r_cnt;
      logic [Fw-1:0]    r_mem [B];

      assign w_wr       = flit_in_wr & w_onehot & w_vc_fld[v];
      // headers always start a packet; non-headers only count while a packet is open
      assign w_take     = w_wr & (w_hdr | (r_st == ST_BODY));
      assign w_full     = (r_cnt == CNTW'(B));
      assign w_empty[v] = (r_cnt == '0);
      assign w_pop[v]   = w_fire & (w_sel == VCw'(v));
      // a full FIFO popped in the same cycle still has room for the incoming flit
      assign w_push     = w_take & (~w_full | w_pop[v]);
      assign w_ev_ovf[v]  = w_take & w_full & ~w_pop[v];
      assign w_ev_orph[v] = w_wr & ~w_hdr & (r_st == ST_IDLE);
      assign w_ev_hib[v]  = w_wr & w_hdr & (r_st == ST_BODY);
      assign w_ev_long[v] = w_wr & ~w_hdr & (r_st == ST_BODY) & ((int'(r_len) + 1) > MAX_PCK_FLIT);
      assign w_head_v[v]  = r_mem[r_rp];

      // per-VC packet tracking FSM and FIFO pointers; FSM advances even when an overflowing flit is dropped
      always_ff @(posedge clk) begin
         if (reset) begin
            r_st  <= ST_IDLE;
            r_len <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_take) begin
               if (w_hdr) begin
                  r_len <= LENW'(1);
                  r_st  <= w_tail ? ST_IDLE : ST_BODY;
               end else begin
                  if (r_len != LENW'(MAX_PCK_FLIT + 1)) r_len <= r_len + LENW'(1);
                  if (w_tail) r_st <= ST_IDLE;
               end
            end
            if (w_push)   r_wp <= f_inc(r_wp);
            if (w_pop[v]) r_rp <= f_inc(r_rp);
            if (w_push && !w_pop[v])      r_cnt <= r_cnt + CNTW'(1);
            else if (!w_push && w_pop[v]) r_cnt <= r_cnt - CNTW'(1);
         end
      end

      // flit storage; contents need no reset because the pointers define occupancy
      always_ff @(posedge clk) begin
         if (w_push) r_mem[r_wp] <= flit_in;
      end
   end

   // round-robin search starting one past the last VC that completed a packet
   always_comb begin
      logic [VCw-1:0] w_cand;
      w_cand   = '0;
      w_gnt_ok = 1'b0;
      w_gnt_vc = r_ptr;
      for (int i = 1; i <= V; i++) begin
         w_cand = VCw'((int'(r_ptr) + i) % V);
         if (!w_gnt_ok && !w_empty[w_cand]) begin
            w_gnt_ok = 1'b1;
            w_gnt_vc = w_cand;
         end
      end
   end

   assign w_sel   = r_lock ? r_lock_vc : w_gnt_vc;
   assign w_valid = r_lock ? ~w_empty[r_lock_vc] : w_gnt_ok;
   assign w_fire  = w_valid & out_ready;
   assign w_head  = w_head_v[w_sel];

   assign w_dec_src = w_head[SRC_LSB+EAw-1:SRC_LSB];

   if (C > 1) begin : g_class
      assign w_dec_class = w_head[CLASS_LSB+Cw-1:CLASS_LSB];
   end else begin : g_noclass
      assign w_dec_class = '0;
   end

   if (DATA_w > 0 && DATA_LSB < FPAYw) begin : g_data
      assign w_dec_data = DOw'(w_head[DATA_MSB:DATA_LSB]);
   end else begin : g_nodata
      assign w_dec_data = '0;
   end

   // packet lock, arbitration pointer, credit return, delivered-packet count and header-field capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock    <= 1'b0;
         r_lock_vc <= '0;
         r_ptr     <= '0;
         r_credit  <= '0;
         r_pck_cnt <= '0;
         r_src     <= '0;
         r_class   <= '0;
         r_data    <= '0;
      end else begin
         r_credit <= w_pop;
         if (w_fire) begin
            if (w_head[Fw-2]) begin
               r_lock <= 1'b0;
               r_ptr  <= w_sel;
               if (r_pck_cnt != '1) r_pck_cnt <= r_pck_cnt + 32'd1;
            end else begin
               r_lock    <= 1'b1;
               r_lock_vc <= w_sel;
            end
            if (w_head[Fw-1]) begin
               r_src   <= w_dec_src;
               r_class <= w_dec_class;
               r_data  <= w_dec_data;
            end
         end
      end
   end

   // sticky protocol error flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err_orphan <= 1'b0;
         r_err_hib    <= 1'b0;
         r_err_long   <= 1'b0;
         r_err_ovf    <= 1'b0;
      end else begin
         if (|w_ev_orph) r_err_orphan <= 1'b1;
         if (|w_ev_hib)  r_err_hib    <= 1'b1;
         if (|w_ev_long) r_err_long   <= 1'b1;
         if (|w_ev_ovf)  r_err_ovf    <= 1'b1;
      end
   end

   assign credit_out      = r_credit;
   assign out_valid       = w_valid;
   assign out_payload     = w_head[FPAYw-1:0];
   assign out_vc          = w_head[FPAYw+V-1:FPAYw];
   assign out_sop         = w_valid & w_head[Fw-1];
   assign out_eop         = w_valid & w_head[Fw-2];
   // header fields track the head flit while it is a header, otherwise the captured copy
   assign out_src_e_addr  = out_sop ? w_dec_src   : r_src;
   assign out_class       = out_sop ? w_dec_class : r_class;
   assign out_data        = out_sop ? w_dec_data  : r_data;
   assign err_orphan      = r_err_orphan;
   assign err_hdr_in_body = r_err_hib;
   assign err_too_long    = r_err_long;
   assign err_overflow    = r_err_ovf;
   assign rx_pck_count    = r_pck_cnt;

endmodule

// File: tb/tb_pck_flit_depacketizer.sv
module tb_pck_flit_depacketizer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   // main instance: B=4, MAX_PCK_FLIT=16
   logic [35:0] flit_in;
   logic        flit_in_wr;
   logic        out_ready;
   logic [1:0]  credit_out;
   logic        out_valid;
   logic [31:0] out_payload;
   logic [1:0]  out_vc;
   logic        out_sop, out_eop;
   logic [3:0]  out_src_e_addr;
   logic [0:0]  out_class;
   logic [8:0]  out_data;
   logic        err_orphan, err_hdr_in_body, err_too_long, err_overflow;
   logic [31:0] rx_pck_count;
   // second instance: B=8, MAX_PCK_FLIT=4
   logic [35:0] flit_in2;
   logic        flit_in_wr2;
   logic        out_ready2;
   logic [1:0]  credit_out2;
   logic        out_valid2;
   logic [31:0] out_payload2;
   logic [1:0]  out_vc2;
   logic        out_sop2, out_eop2;
   logic [3:0]  out_src_e_addr2;
   logic [0:0]  out_class2;
   logic [8:0]  out_data2;
   logic        err_orphan2, err_hdr_in_body2, err_too_long2, err_overflow2;
   logic [31:0] rx_pck_count2;

   pck_flit_depacketizer #(.NOC_ID(0), .DATA_w(9), .B(4), .MAX_PCK_FLIT(16)) u_dut (
      .clk(clk), .reset(reset), .flit_in(flit_in), .flit_in_wr(flit_in_wr),
      .credit_out(credit_out), .out_valid(out_valid), .out_ready(out_ready),
      .out_payload(out_payload), .out_vc(out_vc), .out_sop(out_sop), .out_eop(out_eop),
      .out_src_e_addr(out_src_e_addr), .out_class(out_class), .out_data(out_data),
      .err_orphan(err_orphan), .err_hdr_in_body(err_hdr_in_body),
      .err_too_long(err_too_long), .err_overflow(err_overflow), .rx_pck_count(rx_pck_count));

   pck_flit_depacketizer #(.NOC_ID(0), .DATA_w(9), .B(8), .MAX_PCK_FLIT(4)) u_dut2 (
      .clk(clk), .reset(reset), .flit_in(flit_in2), .flit_in_wr(flit_in_wr2),
      .credit_out(credit_out2), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_payload(out_payload2), .out_vc(out_vc2), .out_sop(out_sop2), .out_eop(out_eop2),
      .out_src_e_addr(out_src_e_addr2), .out_class(out_class2), .out_data(out_data2),
      .err_orphan(err_orphan2), .err_hdr_in_body(err_hdr_in_body2),
      .err_too_long(err_too_long2), .err_overflow(err_overflow2), .rx_pck_count(rx_pck_count2));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   // flit = {hdr, tail, onehot vc[1:0], payload[31:0]}
   function automatic logic [35:0] mk(input logic h, input logic t, input logic [1:0] vc, input logic [31:0] p);
      return {h, t, vc, p};
   endfunction

   // header payload: [3:0] dst, [7:4] src, [11:8] weight, [13:12] be, [22:14] data
   function automatic logic [31:0] hp(input logic [3:0] src, input logic [8:0] dat);
      return {9'b0, dat, 2'b0, 4'b0, src, 4'h0};
   endfunction

   typedef struct {
      logic        wr;
      logic [35:0] flit;
      logic        rdy;
      logic        e_vld;
      logic        e_sop;
      logic        e_eop;
      logic [1:0]  e_vc;
      logic [31:0] e_pay;
      logic [3:0]  e_src;
      logic [8:0]  e_data;
      logic [1:0]  e_cred;
      logic [31:0] e_cnt;
   } vec_t;

   function automatic vec_t mkv(input logic wr, input logic [35:0] f, input logic rdy,
                                input logic vld, input logic sop, input logic eop, input logic [1:0] vc,
                                input logic [31:0] pay, input logic [3:0] src, input logic [8:0] dat,
                                input logic [1:0] cred, input logic [31:0] cnt);
      vec_t r;
      r.wr = wr; r.flit = f; r.rdy = rdy; r.e_vld = vld; r.e_sop = sop; r.e_eop = eop;
      r.e_vc = vc; r.e_pay = pay; r.e_src = src; r.e_data = dat; r.e_cred = cred; r.e_cnt = cnt;
      return r;
   endfunction

   task automatic step(input logic wr, input logic [35:0] f, input logic rdy);
      @(negedge clk);
      flit_in_wr = wr; flit_in = f; out_ready = rdy;
      #1;
   endtask

   task automatic step2(input logic wr, input logic [35:0] f, input logic rdy);
      @(negedge clk);
      flit_in_wr2 = wr; flit_in2 = f; out_ready2 = rdy;
      #1;
   endtask

   vec_t vt[$];

   initial begin
      logic [31:0] p1, a0, a1, a2, a3, b0, b1, b2;
      logic [31:0] tl [6];
      int ccnt0, ccnt1;

      p1 = hp(4'd5, 9'h1A3);
      a0 = hp(4'd2, 9'h011); a1 = 32'hA000_0001; a2 = 32'hA000_0002; a3 = 32'hA000_0003;
      b0 = hp(4'd3, 9'h022); b1 = 32'hB000_0001; b2 = 32'hB000_0002;

      // single-flit packet on VC0, then VC0 4-flit packet interleaved with VC1 3-flit packet
      vt.push_back(mkv(1, mk(1,1,2'b01,p1), 0, 0,0,0,2'b00, 0,     0,    0,      2'b00, 0));
      vt.push_back(mkv(0, 36'd0,            0, 1,1,1,2'b01, p1,    4'd5, 9'h1A3, 2'b00, 0));
      vt.push_back(mkv(0, 36'd0,            1, 1,1,1,2'b01, p1,    4'd5, 9'h1A3, 2'b00, 0));
      vt.push_back(mkv(0, 36'd0,            1, 0,0,0,2'b00, 0,     0,    0,      2'b01, 1));
      vt.push_back(mkv(0, 36'd0,            1, 0,0,0,2'b00, 0,     0,    0,      2'b00, 1));
      vt.push_back(mkv(1, mk(1,0,2'b01,a0), 1, 0,0,0,2'b00, 0,     0,    0,      2'b00, 1));
      vt.push_back(mkv(1, mk(1,0,2'b10,b0), 1, 1,1,0,2'b01, a0,    4'd2, 9'h011, 2'b00, 1));
      vt.push_back(mkv(1, mk(0,0,2'b01,a1), 1, 0,0,0,2'b00, 0,     0,    0,      2'b01, 1));
      vt.push_back(mkv(1, mk(0,0,2'b10,b1), 1, 1,0,0,2'b01, a1,    4'd2, 9'h011, 2'b00, 1));
      vt.push_back(mkv(1, mk(0,0,2'b01,a2), 1, 0,0,0,2'b00, 0,     0,    0,      2'b01, 1));
      vt.push_back(mkv(1, mk(0,1,2'b10,b2), 1, 1,0,0,2'b01, a2,    4'd2, 9'h011, 2'b00, 1));
      vt.push_back(mkv(1, mk(0,1,2'b01,a3), 1, 0,0,0,2'b00, 0,     0,    0,      2'b01, 1));
      vt.push_back(mkv(0, 36'd0,            1, 1,0,1,2'b01, a3,    4'd2, 9'h011, 2'b00, 1));
      vt.push_back(mkv(0, 36'd0,            1, 1,1,0,2'b10, b0,    4'd3, 9'h022, 2'b01, 2));
      vt.push_back(mkv(0, 36'd0,            1, 1,0,0,2'b10, b1,    4'd3, 9'h022, 2'b10, 2));
      vt.push_back(mkv(0, 36'd0,            1, 1,0,1,2'b10, b2,    4'd3, 9'h022, 2'b10, 2));
      vt.push_back(mkv(0, 36'd0,            1, 0,0,0,2'b00, 0,     0,    0,      2'b10, 3));
      vt.push_back(mkv(0, 36'd0,            1, 0,0,0,2'b00, 0,     0,    0,      2'b00, 3));

      reset = 1'b1;
      flit_in = '0; flit_in_wr = 1'b0; out_ready = 1'b0;
      flit_in2 = '0; flit_in_wr2 = 1'b0; out_ready2 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;

      // reset state
      chk("rst.valid", out_valid, 0);
      chk("rst.credit", credit_out, 0);
      chk("rst.errs", {err_orphan, err_hdr_in_body, err_too_long, err_overflow}, 0);
      chk("rst.count", rx_pck_count, 0);
      chk("rst.fields", {out_src_e_addr, out_class, out_data}, 0);

      // table-driven vectors
      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].wr, vt[i].flit, vt[i].rdy);
         chk($sformatf("v%0d.valid", i), out_valid, vt[i].e_vld);
         chk($sformatf("v%0d.credit", i), credit_out, vt[i].e_cred);
         chk($sformatf("v%0d.count", i), rx_pck_count, vt[i].e_cnt);
         if (vt[i].e_vld) begin
            chk($sformatf("v%0d.sop_eop", i), {out_sop, out_eop}, {vt[i].e_sop, vt[i].e_eop});
            chk($sformatf("v%0d.vc", i), out_vc, vt[i].e_vc);
            chk($sformatf("v%0d.payload", i), out_payload, vt[i].e_pay);
            chk($sformatf("v%0d.src", i), out_src_e_addr, vt[i].e_src);
            chk($sformatf("v%0d.data", i), out_data, vt[i].e_data);
         end
      end
      chk("tbl.errs", {err_orphan, err_hdr_in_body, err_too_long, err_overflow}, 0);

      // overflow: four writes fill VC1, the fifth is dropped
      step(1, mk(1,0,2'b10,hp(4'd7, 9'h0)), 0);
      chk("ovf.w0.credit", credit_out, 0);
      for (int i = 1; i <= 3; i++) begin
         step(1, mk(0,0,2'b10,32'hC000_0000 + i), 0);
         chk($sformatf("ovf.w%0d.credit", i), credit_out, 0);
      end
      step(1, mk(0,0,2'b10,32'hC000_0004), 0);
      chk("ovf.before", err_overflow, 0);
      step(0, 36'd0, 0);
      chk("ovf.after", err_overflow, 1);
      chk("ovf.nocredit", credit_out, 0);
      ccnt0 = 0; ccnt1 = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 36'd0, 1);
         ccnt0 += int'(credit_out[0]);
         ccnt1 += int'(credit_out[1]);
         if (i == 0) chk("ovf.drain.sop", out_sop, 1);
         if (i == 3) chk("ovf.drain.last", out_payload, 32'hC000_0003);
         if (i == 5) chk("ovf.lock_empty.valid", out_valid, 0);
      end
      chk("ovf.credits_vc1", ccnt1, 4);
      chk("ovf.credits_vc0", ccnt0, 0);
      step(1, mk(0,1,2'b10,32'hC000_0005), 1);
      repeat (3) step(0, 36'd0, 1);
      chk("ovf.tail.count", rx_pck_count, 4);

      // orphan body flit on idle VC0, then header mid-packet
      step(1, mk(0,0,2'b01,32'hD000_0000), 1);
      step(0, 36'd0, 1);
      chk("orph.flag", err_orphan, 1);
      chk("orph.valid", out_valid, 0);
      chk("orph.hib_clear", err_hdr_in_body, 0);
      step(0, 36'd0, 1);
      chk("orph.credit", credit_out, 0);
      step(1, mk(1,0,2'b01,hp(4'd4, 9'h044)), 1);
      step(0, 36'd0, 1);
      chk("hib.first_hdr.src", out_src_e_addr, 4);
      step(1, mk(1,0,2'b01,hp(4'd6, 9'h155)), 1);
      step(0, 36'd0, 1);
      chk("hib.flag", err_hdr_in_body, 1);
      chk("hib.sop", {out_valid, out_sop}, 2'b11);
      chk("hib.fields", {out_src_e_addr, out_data}, {4'd6, 9'h155});
      step(1, mk(0,1,2'b01,32'hD000_0001), 1);
      repeat (3) step(0, 36'd0, 1);
      chk("hib.count", rx_pck_count, 5);

      // too-long packet on the B=8, MAX_PCK_FLIT=4 instance
      tl[0] = hp(4'd1, 9'h0AA);
      for (int i = 1; i < 6; i++) tl[i] = 32'hE000_0000 + i;
      for (int i = 0; i < 6; i++) begin
         step2(1, mk(i == 0, i == 5, 2'b01, tl[i]), 0);
         if (i == 4) chk("long.at4", err_too_long2, 0);
         if (i == 5) chk("long.at5", err_too_long2, 1);
      end
      step2(0, 36'd0, 0);
      chk("long.no_ovf", err_overflow2, 0);
      chk("long.nocredit", credit_out2, 0);
      for (int i = 0; i < 6; i++) begin
         step2(0, 36'd0, 1);
         chk($sformatf("long.f%0d.valid", i), out_valid2, 1);
         chk($sformatf("long.f%0d.flags", i), {out_sop2, out_eop2}, {i == 0, i == 5});
         chk($sformatf("long.f%0d.payload", i), out_payload2, tl[i]);
      end
      step2(0, 36'd0, 1);
      chk("long.count", rx_pck_count2, 1);
      chk("long.valid_end", out_valid2, 0);

      // reset mid-packet with two flits buffered
      step(1, mk(1,0,2'b01,hp(4'd8, 9'h0)), 0);
      step(1, mk(0,0,2'b01,32'hF000_0001), 0);
      step(0, 36'd0, 0);
      chk("rstm.pre.valid", out_valid, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      step(0, 36'd0, 0);
      reset = 1'b0;
      chk("rstm.valid", out_valid, 0);
      chk("rstm.errs", {err_orphan, err_hdr_in_body, err_too_long, err_overflow}, 0);
      chk("rstm.credit", credit_out, 0);
      chk("rstm.count", rx_pck_count, 0);
      chk("rstm.src", out_src_e_addr, 0);
      step(1, mk(1,1,2'b01,hp(4'd9, 9'h0F0)), 1);
      chk("rstm.credit2", credit_out, 0);
      step(0, 36'd0, 1);
      chk("rstm.fresh.flags", {out_valid, out_sop, out_eop}, 3'b111);
      chk("rstm.fresh.fields", {out_src_e_addr, out_data}, {4'd9, 9'h0F0});
      step(0, 36'd0, 1);
      chk("rstm.fresh.credit", credit_out, 2'b01);
      chk("rstm.fresh.count", rx_pck_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
